piso_serializer: RTL and testbench

- Downstream consumer of the 4-bit parallel register stage. Accepts one parallel word per handshake and shifts it out one bit per clock on a serial line.
- Presents a per-bit valid and a last-bit flag.
- Supports back-to-back words with no idle cycle between them, so serial throughput equals one bit per clock.

---
 rtl/piso_serializer.sv | 77 +++++++
 tb/tb_piso_serializer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: one word per handshake, one bit per clock, gapless back-to-back.
// Optional PISO_PARITY_EN appends an even-parity bit after the data bits of each word.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);
  localparam int CW = $clog2(WIDTH+1);
`ifdef PISO_PARITY_EN
  localparam int LAST_CNT = WIDTH;
`else
  localparam int LAST_CNT = WIDTH-1;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] shreg, shreg_shift;
  logic [CW-1:0]    cnt;
  logic             last, accept, data_bit;

  assign last        = (state == SHIFT) && (cnt == CW'(LAST_CNT));
  assign load_ready  = (state == IDLE) || last;
  assign accept      = load_valid && load_ready;
  assign done        = last;
  assign sout_valid  = (state == SHIFT);
  assign data_bit    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shreg_shift = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

`ifdef PISO_PARITY_EN
  logic par;
  // Parity latched at capture so the shifted-out register needn't be preserved.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      par <= 1'b0;
    else if (accept) par <= ^D;
  end
  assign sout = (state == SHIFT) && ((cnt == CW'(WIDTH)) ? par : data_bit);
`else
  assign sout = (state == SHIFT) && data_bit;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A reload on the last-bit edge takes priority over the final shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= D;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      shreg <= shreg_shift;
      cnt   <= last ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances driven in parallel, checked against
// a queue-of-pending-bits model every cycle, plus directed literal sequences.
module tb_piso_serializer;
  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int NB = 5;
  localparam logic [4:0] S1M = 5'b10100, S1L = 5'b01010, S2A = 5'b11110, S2B = 5'b01100,
                         S3M = 5'b11011, S3L = 5'b10111;
`else
  localparam int NB = 4;
  localparam logic [4:0] S1M = 5'b01010, S1L = 5'b00101, S2A = 5'b01111, S2B = 5'b00110,
                         S3M = 5'b01101, S3L = 5'b01011;
`endif

  logic clk = 1'b0, reset = 1'b0, load_valid = 1'b0;
  logic [W-1:0] D = '0;
  logic rdy_m, sout_m, sv_m, done_m, rdy_l, sout_l, sv_l, done_l;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .D(D), .load_valid(load_valid),
    .load_ready(rdy_m), .sout(sout_m), .sout_valid(sv_m), .done(done_m));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .D(D), .load_valid(load_valid),
    .load_ready(rdy_l), .sout(sout_l), .sout_valid(sv_l), .done(done_l));

  // Model: the bits still to appear on sout, front = bit on the line this cycle.
  typedef struct { logic m; logic l; logic last; } ent_t;
  ent_t q[$];
  logic mdl_rdy;

  always @(posedge clk or negedge reset) begin
    if (!reset) q.delete();
    else begin
      mdl_rdy = (q.size() <= 1);
      if (q.size() > 0) void'(q.pop_front());
      if (load_valid && mdl_rdy)
        for (int i = 0; i < NB; i++)
          q.push_back('{m: (i < W) ? D[W-1-i] : ^D, l: (i < W) ? D[i] : ^D, last: (i == NB-1)});
    end
  end

  always @(negedge clk) begin : cmp
    logic ev;
    logic [7:0] got, exp;
    ev  = (q.size() > 0);
    exp = {ev && q[0].m, ev && q[0].l, ev, ev, ev && q[0].last, ev && q[0].last,
           !ev || q[0].last, !ev || q[0].last};
    got = {sout_m, sout_l, sv_m, sv_l, done_m, done_l, rdy_m, rdy_l};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model t=%0t got=%b want=%b", $time, got, exp);
    end
  end

  task automatic obs(input string nm, input logic em, input logic el, input logic v,
                     input logic d, input logic r);
    logic [7:0] got, exp;
    got = {sout_m, sout_l, sv_m, sv_l, done_m, done_l, rdy_m, rdy_l};
    exp = {em, el, v, v, d, d, r, r};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b", nm, $time, got, exp);
    end
  endtask

  task automatic drv(input logic lv, input logic [W-1:0] d);
    load_valid = lv;
    D = d;
    @(negedge clk);
  endtask

  // Checks one word's NB cycles; inputs lv_b/d_b are driven while busy, lv_e/d_e at the last bit.
  task automatic word_seq(input string nm, input logic [4:0] sm, input logic [4:0] sl,
                          input logic lv_b, input logic [W-1:0] d_b,
                          input logic lv_e, input logic [W-1:0] d_e);
    for (int k = 0; k < NB; k++) begin
      obs(nm, sm[NB-1-k], sl[NB-1-k], 1'b1, k == NB-1, k == NB-1);
      if (k == NB-1) drv(lv_e, d_e);
      else           drv(lv_b, d_b);
    end
  endtask

  initial begin
    @(negedge clk);
    obs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 reset = 1'b1;
    @(negedge clk);

    drv(1'b1, 4'b1010);
    word_seq("single", S1M, S1L, 1'b0, 4'b0000, 1'b0, 4'b0000);
    obs("idle_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    drv(1'b1, 4'b1111);
    word_seq("b2b_a", S2A, S2A, 1'b1, 4'b0110, 1'b1, 4'b0110);
    word_seq("b2b_b", S2B, S2B, 1'b0, 4'b0000, 1'b0, 4'b0000);

    drv(1'b1, 4'b1101);
    word_seq("busy", S3M, S3L, 1'b1, 4'b0000, 1'b0, 4'b0000);
    obs("idle_busy", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    drv(1'b1, 4'b0101);
    obs("rst_bit0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drv(1'b0, 4'b0000);
    obs("rst_bit1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 obs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    drv(1'b1, 4'b0110);
    word_seq("post_rst", S2B, S2B, 1'b0, 4'b0000, 1'b0, 4'b0000);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        #3 reset = 1'b0;
        #4 reset = 1'b1;
        @(negedge clk);
      end
      drv($urandom_range(0, 3) != 0, W'($urandom));
    end
    drv(1'b0, 4'b0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
